// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

  // Read-mode encodings for the FWFT parameter
  localparam int FWFT_REGISTERED = 0;
  localparam int FWFT_SHOWAHEAD  = 1;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  function automatic cnt_op_e cnt_op(input logic wr_accept, input logic rd_accept);
    if (wr_accept && !rd_accept) return CNT_INC;
    if (rd_accept && !wr_accept) return CNT_DEC;
    return CNT_HOLD;
  endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// Simple dual-port storage: one write port, one read port whose output is
// either registered (block-RAM style) or combinational (show-ahead).
module fifo_ram_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = FWFT_REGISTERED
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  generate
    if (FWFT == FWFT_SHOWAHEAD) begin : g_comb_read
      assign rdata = mem[raddr];
    end else begin : g_reg_read
      logic [DATA_WIDTH-1:0] rdata_reg;
      // Output register keeps its value between reads; only reset clears it
      always_ff @(posedge clk) begin
        if (!rst_n)  rdata_reg <= '0;
        else if (re) rdata_reg <= mem[raddr];
      end
      assign rdata = rdata_reg;
    end
  endgenerate

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parameterised FIFO with registered-read or first-word-fall-through
// output, count-derived status flags and sticky overflow/underflow.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FWFT       = FWFT_REGISTERED,
  parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_C    = AF_LEVEL[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_C    = AE_LEVEL[ADDR_WIDTH:0];

  generate
    if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_level
      $error("fifo_sync_param: AF_LEVEL and AE_LEVEL must not exceed DEPTH");
    end
  endgenerate

  logic [ADDR_WIDTH:0]   wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg, count_next;
  logic                  overflow_reg, underflow_reg;
  logic                  wr_accept, rd_accept;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_C);
  assign almost_full  = (count_reg >= AF_C);
  assign almost_empty = (count_reg <= AE_C);
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // A full FIFO never takes a write, even when a read frees a slot this cycle
  assign wr_accept = wr_en && !full  && !flush;
  assign rd_accept = rd_en && !empty && !flush;

  always_comb begin
    count_next = count_reg;
    unique case (cnt_op(wr_accept, rd_accept))
      CNT_INC: count_next = count_reg + 1'b1;
      CNT_DEC: count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_accept) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      if (wr_en && full)  overflow_reg  <= 1'b1;
      if (rd_en && empty) underflow_reg <= 1'b1;
    end
  end

  fifo_ram_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .FWFT       (FWFT)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_accept),
    .waddr (wr_ptr_reg[ADDR_WIDTH-1:0]),
    .wdata (din),
    .re    (rd_accept),
    .raddr (rd_ptr_reg[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  assign dout = ram_rdata;

  generate
    if (FWFT == FWFT_SHOWAHEAD) begin : g_valid_fwft
      assign valid = !empty;
    end else begin : g_valid_reg
      logic valid_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)     valid_reg <= 1'b0;
        else if (flush) valid_reg <= 1'b0;
        else            valid_reg <= rd_accept;
      end
      assign valid = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboard bench: registered-read and FWFT instances share one stimulus stream.
module tb_fifo_sync_param;

  localparam int DW = 16;
  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] din   = '0;

  logic [DW-1:0] dout0, dout1;
  logic          valid0, valid1;
  logic          empty0, full0, af0, ae0, ov0, un0;
  logic          empty1, full1, af1, ae1, ov1, un1;
  logic [AW:0]   cnt0, cnt1;

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout0), .valid(valid0), .empty(empty0), .full(full0), .almost_full(af0),
    .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0));

  fifo_sync_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout1), .valid(valid1), .empty(empty1), .full(full1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1));

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mq[$];     // reference contents
  logic [DW-1:0] exp_q[$];  // words owed on the registered-read output
  bit m_ov = 1'b0;
  bit m_un = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Registered-read monitor: every valid beat must match the oldest owed word
  always @(negedge clk) begin
    if (valid0 === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_valid", {31'd0, valid0}, 32'd0);
      else                   chk("rd_data", {16'd0, dout0}, {16'd0, exp_q.pop_front()});
    end
  end

  task automatic check_status();
    int sz;
    logic [8:0] exp_st;
    sz = mq.size();
    exp_st = {sz[2:0], sz == 0, sz == 4, sz >= 3, sz <= 1, m_ov, m_un};
    chk("status0", {23'd0, cnt0, empty0, full0, af0, ae0, ov0, un0}, {23'd0, exp_st});
    chk("status1", {23'd0, cnt1, empty1, full1, af1, ae1, ov1, un1}, {23'd0, exp_st});
    chk("fwft_valid", {31'd0, valid1}, {31'd0, sz != 0});
    if (sz != 0) chk("fwft_dout", {16'd0, dout1}, {16'd0, mq[0]});
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit rst);
    bit was_full, was_empty;
    was_full  = (mq.size() == 4);
    was_empty = (mq.size() == 0);
    wr_en = w; din = d; rd_en = r; flush = f; rst_n = !rst;
    if (rst || f) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (w && was_full)  m_ov = 1'b1;
      if (r && was_empty) m_un = 1'b1;
      if (r && !was_empty) exp_q.push_back(mq.pop_front());
      if (w && !was_full)  mq.push_back(d);
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst_n = 1'b1;
    $display("txn wr=%0b din=%04h rd=%0b flush=%0b rst=%0b -> count=%0d dout0=%04h valid0=%0b dout1=%04h valid1=%0b",
             w, d, r, f, rst, cnt0, dout0, valid0, dout1, valid1);
    check_status();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);
    chk("rst_dout0", {16'd0, dout0}, 32'd0);
    chk("rst_valid0", {31'd0, valid0}, 32'd0);

    // Two words, read back with one-cycle latency
    step(1, 16'h0011, 0, 0, 0);
    step(1, 16'h0022, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("lat_valid1", {31'd0, valid0}, 32'd1);
    chk("lat_dout1", {16'd0, dout0}, 32'h0011);
    step(0, 16'h0, 1, 0, 0);
    chk("lat_dout2", {16'd0, dout0}, 32'h0022);
    step(0, 16'h0, 0, 0, 0);
    chk("idle_valid", {31'd0, valid0}, 32'd0);
    chk("hold_dout", {16'd0, dout0}, 32'h0022);
    chk("empty_after", {31'd0, empty0}, 32'd1);

    // Fill past full
    for (int i = 0; i < 5; i++) begin
      step(1, 16'(16'h00A0 + i), 0, 0, 0);
      if (i == 2) begin
        chk("af_at3", {31'd0, af0}, 32'd1);
        chk("notfull_at3", {31'd0, full0}, 32'd0);
      end
      if (i == 3) chk("full_at4", {31'd0, full0}, 32'd1);
      if (i == 4) begin
        chk("ovf_set", {31'd0, ov0}, 32'd1);
        chk("cnt_after_drop", {29'd0, cnt0}, 32'd4);
      end
    end
    step(0, 16'h0, 0, 0, 0);
    chk("ovf_sticky", {31'd0, ov0}, 32'd1);

    // Read and write together while full: write dropped
    step(1, 16'h00EE, 1, 0, 0);
    chk("full_rw_cnt", {29'd0, cnt0}, 32'd3);

    step(0, 16'h0, 0, 1, 0);
    chk("flush_cnt", {29'd0, cnt0}, 32'd0);
    chk("flush_ovf", {31'd0, ov0}, 32'd0);

    // Steady-state streaming across pointer wrap
    step(1, 16'h00B0, 0, 0, 0);
    step(1, 16'h00B1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 16'(16'h00C0 + i), 1, 0, 0);
      chk("stream_cnt", {29'd0, cnt0}, 32'd2);
    end
    step(0, 16'h0, 1, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    chk("stream_last", {16'd0, dout0}, 32'h00C9);
    step(0, 16'h0, 0, 0, 0);

    // Show-ahead presentation
    step(1, 16'hBEEF, 0, 0, 0);
    chk("fwft_show_valid", {31'd0, valid1}, 32'd1);
    chk("fwft_show_dout", {16'd0, dout1}, 32'h0000BEEF);
    step(0, 16'h0, 1, 0, 0);
    chk("fwft_pop_valid", {31'd0, valid1}, 32'd0);

    // Underflow then flush
    step(0, 16'h0, 1, 0, 0);
    chk("unf_set", {31'd0, un0}, 32'd1);
    step(0, 16'h0, 0, 0, 0);
    chk("unf_sticky", {31'd0, un1}, 32'd1);
    step(0, 16'h0, 0, 1, 0);
    chk("flush_unf", {31'd0, un0}, 32'd0);
    chk("flush_empty", {31'd0, empty0}, 32'd1);

    // Reset in the middle of a burst, with flush and requests also active
    step(1, 16'h00D1, 0, 0, 0);
    step(1, 16'h00D2, 0, 0, 0);
    step(1, 16'h00D3, 0, 0, 0);
    step(0, 16'h0, 1, 0, 0);
    step(1, 16'h00D4, 1, 1, 1);
    chk("midrst_cnt", {29'd0, cnt0}, 32'd0);
    chk("midrst_dout0", {16'd0, dout0}, 32'd0);
    chk("midrst_valid0", {31'd0, valid0}, 32'd0);
    chk("midrst_valid1", {31'd0, valid1}, 32'd0);
    chk("midrst_af_ae", {30'd0, af0, ae0}, 32'd1);

    step(0, 16'h0, 0, 0, 0);
    step(0, 16'h0, 0, 0, 0);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
